// File: rtl/alu_rr_sequencer.sv
// Two-port round-robin front end for a 16-bit ALU: single-cycle add/sub/shift,
// 16-step shift-add multiply, one command in flight, result held until accepted.
module alu_rr_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_sel,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_sel,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t               state, state_nxt;
    logic                 last_grant;
    logic [1:0]           op_sel;
    logic [WIDTH-1:0]     op_a, op_b;
    logic                 op_cin;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;

    logic                 grant_any, grant_id;
    logic [1:0]           g_sel;
    logic [WIDTH-1:0]     g_a, g_b;
    logic                 g_cin;

    logic [WIDTH:0]       sum, diff;
    logic                 add_cin;
    logic [2*WIDTH-1:0]   ex_data;
    logic                 ex_carry, ex_ovf;
    logic [2*WIDTH-1:0]   pp, mul_sum;

    // Arbitration and next state; reset forces the ready outputs low.
    always_comb begin
        state_nxt  = state;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        g_sel      = req0_sel;
        g_a        = req0_a;
        g_b        = req0_b;
        g_cin      = req0_cin;
        case (state)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    grant_any = 1'b1;
                    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    if (grant_id) begin
                        g_sel = req1_sel;
                        g_a   = req1_a;
                        g_b   = req1_b;
                        g_cin = req1_cin;
                    end
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = (g_sel == 2'b10) ? MUL : EXEC;
                end
            end
            EXEC: state_nxt = DONE;
            MUL:  if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Single-cycle results; sel 01 with cin=0 falls back to a plain add.
    always_comb begin
        add_cin  = (op_sel == 2'b00) ? op_cin : 1'b0;
        sum      = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, add_cin};
        diff     = {1'b0, op_a} - {1'b0, op_b};
        ex_data  = '0;
        ex_carry = 1'b0;
        ex_ovf   = 1'b0;
        if (op_sel == 2'b01 && op_cin) begin
            ex_data  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            ex_carry = diff[WIDTH];
            ex_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        end else if (op_sel == 2'b11) begin
            if (op_b < WIDTH'(WIDTH))
                ex_data = {op_a << op_b[CW-1:0], op_a >> op_b[CW-1:0]};
        end else begin
            ex_data  = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            ex_carry = sum[WIDTH];
            ex_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    assign pp      = op_b[cnt] ? ({{WIDTH{1'b0}}, op_a} << cnt) : '0;
    assign mul_sum = acc + pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_sel     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                last_grant <= grant_id;
                rsp_id     <= grant_id;
                op_sel     <= g_sel;
                op_a       <= g_a;
                op_b       <= g_b;
                op_cin     <= g_cin;
                cnt        <= '0;
                acc        <= '0;
            end
            if (state == EXEC) begin
                rsp_data  <= ex_data;
                rsp_carry <= ex_carry;
                rsp_ovf   <= ex_ovf;
            end
            if (state == MUL) begin
                acc <= mul_sum;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    rsp_data  <= mul_sum;
                    rsp_carry <= 1'b0;
                    rsp_ovf   <= |mul_sum[2*WIDTH-1:WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: latency, arithmetic results, flags,
// round-robin order and reset during a multiply.
module tb_alu_rr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin;
    logic [1:0]  req0_sel;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [1:0]  req1_sel;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf, busy;
    logic [31:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    bit busy_ok;
    bit seen_valid;
    int w;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, check it is accepted this cycle, then scramble operands.
    task automatic send(input bit port, input logic [1:0] sel, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
        if (port) begin
            req1_valid = 1'b1; req1_sel = sel; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_sel = sel; req0_a = a; req0_b = b; req0_cin = cin;
        end
        #1;
        check("ready_granted", port ? req1_ready : req0_ready, 1);
        check("ready_other", port ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'hDEAD; req0_b = 16'hBEEF; req1_a = 16'hDEAD; req1_b = 16'hBEEF;
        req0_sel = 2'b01; req1_sel = 2'b01; req0_cin = ~cin; req1_cin = ~cin;
    endtask

    // Latency counted in cycles after the acceptance cycle.
    task automatic await_rsp();
        lat = 1;
        busy_ok = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic take_rsp(input string tag, input logic id, input logic [31:0] data,
                            input logic carry, input logic ovf);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_data"}, rsp_data, data);
        check({tag, "_carry"}, rsp_carry, carry);
        check({tag, "_ovf"}, rsp_ovf, ovf);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, rsp_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_sel = 2'b00; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_sel = 2'b00; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        tick(); tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_id", rsp_id, 0);
        check("rst_data", rsp_data, 0);
        check("rst_flags", {rsp_carry, rsp_ovf}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        send(0, 2'b00, 16'hFFFF, 16'h0001, 1'b1);
        await_rsp();
        check("add_lat", lat, 2);
        take_rsp("add", 0, 32'h0000_0001, 1, 0);

        send(1, 2'b01, 16'h8000, 16'h0001, 1'b1);
        await_rsp();
        check("sub1_lat", lat, 2);
        take_rsp("sub1", 1, 32'h0000_7FFF, 0, 1);

        send(1, 2'b01, 16'h0003, 16'h0005, 1'b1);
        await_rsp();
        take_rsp("sub2", 1, 32'h0000_FFFE, 1, 0);

        send(0, 2'b01, 16'h7FFF, 16'h0001, 1'b0);
        await_rsp();
        take_rsp("addsub_add", 0, 32'h0000_8000, 0, 1);

        send(0, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0);
        await_rsp();
        check("mul_lat", lat, 17);
        check("mul_busy", busy_ok, 1);
        take_rsp("mul_big", 0, 32'hFFFE_0001, 0, 1);

        send(1, 2'b10, 16'h0003, 16'h0005, 1'b1);
        await_rsp();
        check("mul_small_lat", lat, 17);
        take_rsp("mul_small", 1, 32'h0000_000F, 0, 0);

        send(0, 2'b11, 16'h00F0, 16'd4, 1'b0);
        await_rsp();
        check("shl_lat", lat, 2);
        take_rsp("shift4", 0, 32'h0F00_000F, 0, 0);

        send(0, 2'b11, 16'h00F0, 16'd16, 1'b0);
        await_rsp();
        take_rsp("shift16", 0, 32'h0000_0000, 0, 0);

        // Reset during a multiply, eight cycles after acceptance.
        send(1, 2'b10, 16'h1234, 16'h5678, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        check("mid_mul_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("rstmul_busy", busy, 0);
        check("rstmul_valid", rsp_valid, 0);
        check("rstmul_data", rsp_data, 0);
        check("rstmul_id", rsp_id, 0);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || busy) seen_valid = 1'b1;
            tick();
        end
        check("rstmul_no_rsp", seen_valid, 0);

        // Both ports valid continuously with rsp_ready high: 0,1,0,1 every 3 cycles.
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_sel = 2'b00; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_sel = 2'b00; req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (!(req0_ready || req1_ready) && w < 5) begin
                tick();
                w++;
            end
            check("rr_wait", w, 0);
            check("rr_grant", {req1_ready, req0_ready}, (g % 2) ? 2'b10 : 2'b01);
            tick();
            check("rr_exec_ready", {req1_ready, req0_ready}, 0);
            tick();
            check("rr_valid", rsp_valid, 1);
            check("rr_id", rsp_id, g % 2);
            check("rr_data", rsp_data, (g % 2) ? 32'h0000_0031 : 32'h0000_0003);
            check("rr_done_ready", {req1_ready, req0_ready}, 0);
            tick();
            check("rr_done_1cyc", rsp_valid, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_rr_sequencer.md
# alu_rr_sequencer

Two-requester front end for the 16-bit ALU datapath (add, add/subtract, multiply, shift). Arbitrates round-robin between two command ports, captures operands, executes single-cycle operations in one cycle and multiplication as a 16-iteration shift-add sequence, then holds a tagged result until the consumer accepts it. One command is in flight at a time.

## Interface
- WIDTH, 16, operand width; results are 2*WIDTH bits.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_sel  in  2  00 add, 01 add/sub, 10 multiply, 11 shift.
- req0_a, req0_b  in  WIDTH  operands.
- req0_cin  in  1  sel 00: carry-in; sel 01: 1 = subtract, 0 = add; otherwise ignored.
- req1_valid, req1_ready, req1_sel, req1_a, req1_b, req1_cin: same for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_data  out  2*WIDTH  result.
- rsp_carry  out  1  carry/borrow flag.
- rsp_ovf  out  1  overflow flag.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: if any reqN_valid, grant one; reqN_ready = 1 combinationally for the granted port only (requires state IDLE). Capture sel/a/b/cin, id. Go to EXEC (sel != 10) or MUL (sel 10).
- Arbitration: last-grant pointer; both valid -> grant the port not last granted; one valid -> grant it. Pointer updates on every grant. After reset requester 0 wins a tie.
- EXEC (1 cycle), results registered, then DONE:
  - sel 00: data = zero-extended a+b+cin (WIDTH bits); carry = carry-out; ovf = signed overflow.
  - sel 01, cin=1: data = zero-extended a-b (two's complement); carry = borrow (1 iff a<b unsigned); ovf = signed overflow. cin=0: as sel 00 with carry-in 0.
  - sel 11: data = {a<<b, a>>b} (left in upper half, logical); b >= WIDTH gives 0 for both halves; carry = ovf = 0.
- MUL: unsigned shift-add, one partial product per cycle, counter 0..WIDTH-1; after WIDTH cycles data = a*b (full 2*WIDTH bits), carry = 0, ovf = 1 iff upper WIDTH bits nonzero. Go to DONE.
- DONE: rsp_valid = 1, rsp_id/data/flags stable. rsp_valid && rsp_ready -> IDLE. No new grant in the handshake cycle.
- Operand changes on request ports after acceptance have no effect.

## Timing
- Reset: state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_carry 0, rsp_ovf 0, busy 0, reqN_ready 0 during rst, pointer favours requester 0, counter 0.
- Acceptance in cycle N: single-cycle op -> rsp_valid from cycle N+2; multiply -> rsp_valid from cycle N+1+WIDTH (N+17).
- Response handshake in cycle M: rsp_valid 0 at M+1; earliest next acceptance at M+1; back-to-back single-cycle throughput = one command per 3 cycles.
- rsp_ready held high throughout: DONE lasts exactly one cycle.
- rst during EXEC/MUL/DONE: in-flight command dropped, no response, all outputs to reset values next cycle.
- rsp_ready while not DONE: ignored.

## Test plan
- Reset, then req0 sel 00 a=0xFFFF b=0x0001 cin=1 -> req0_ready cycle N, rsp_valid at N+2, data=0x00000001, carry=1, ovf=0, id=0.
- req1 sel 01 cin=1 a=0x8000 b=0x0001 -> data=0x00007FFF, carry=0, ovf=1, id=1; a=0x0003 b=0x0005 -> data=0x0000FFFE, carry=1.
- req0 sel 10 a=0xFFFF b=0xFFFF -> rsp_valid exactly at N+17, data=0xFFFE0001, ovf=1; busy high N+1..N+17.
- Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id follows; each port's ready pulses once per grant.
- sel 11 a=0x00F0 b=4 -> data=0x0F00000F; b=16 -> data=0x00000000.
- rst asserted mid-MUL (cycle N+8) -> no rsp_valid, busy 0 next cycle; subsequent tie grants requester 0.
